// File: rtl/wb_select_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select_stage_if
//  Description : Bundle between the MEM stage, the write-back select stage
//                and the register file. Carries the upstream valid/ready
//                handshake with instruction fields, and the downstream
//                register-file write port with status.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_select_stage_if #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int SEL_W = 2,
    parameter int RA_W  = 5
);
    // upstream side
    logic                 in_valid;
    logic                 in_ready;
    logic [NSRC*XLEN-1:0] src_data;
    logic [SEL_W-1:0]     wb_sel;
    logic                 reg_write;
    logic [RA_W-1:0]      rd_addr;
    logic [2:0]           ld_funct3;
    logic [2:0]           byte_off;
    // downstream side
    logic                 out_ready;
    logic                 rf_we;
    logic [RA_W-1:0]      rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 out_valid;
    logic                 sel_err;
    logic [31:0]          wb_count;

    // Driver of instructions and consumer of register writes
    modport master (
        output in_valid, src_data, wb_sel, reg_write, rd_addr, ld_funct3, byte_off, out_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata, out_valid, sel_err, wb_count
    );

    // The write-back stage itself
    modport slave (
        input  in_valid, src_data, wb_sel, reg_write, rd_addr, ld_funct3, byte_off, out_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata, out_valid, sel_err, wb_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select_stage
//  Description : Registered write-back stage. Selects one of NSRC result
//                sources, aligns and extends load data, suppresses x0
//                writes, flags illegal selects and counts committed writes.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_select_stage #(
    parameter int XLEN    = 32,
    parameter int NSRC    = 4,
    parameter int SEL_W   = 2,
    parameter int MEM_IDX = 1,
    parameter int RA_W    = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_select_stage_if.slave bus
);
    // byte-offset bits that address a byte inside one XLEN word
    localparam int OFF_W = $clog2(XLEN / 8);

    logic [XLEN-1:0] ld_word;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] sel_data;
    logic            sel_ok;
    logic            accept;
    logic            commit;

    logic            out_valid_q, out_valid_d;
    logic            rf_we_q,     rf_we_d;
    logic [RA_W-1:0] rf_waddr_q,  rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q,  rf_wdata_d;
    logic            sel_err_q,   sel_err_d;
    logic [31:0]     wb_count_q,  wb_count_d;

    // upper byte_off bits are meaningless for narrow datapaths
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.byte_off};

    assign bus.in_ready = !out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign commit       = out_valid_q & rf_we_q & bus.out_ready;

    // Load alignment: shift the memory word down to the addressed byte, then extend
    always_comb begin
        ld_word  = bus.src_data[MEM_IDX*XLEN +: XLEN];
        ld_shift = ld_word >> {bus.byte_off[OFF_W-1:0], 3'b000};
        ld_data  = ld_word;
        case (bus.ld_funct3)
            3'b000:  ld_data = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_data = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_data = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_data = XLEN'(ld_shift[7:0]);
            3'b101:  ld_data = XLEN'(ld_shift[15:0]);
            3'b110:  if (XLEN == 64) ld_data = XLEN'(ld_shift[31:0]);
            3'b011:  if (XLEN == 64) ld_data = ld_shift;
            default: ld_data = ld_word;
        endcase
    end

    // Source mux; a select with no matching source yields zero data and sel_ok=0
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.wb_sel == SEL_W'(i)) begin
                sel_ok   = 1'b1;
                sel_data = (i == MEM_IDX) ? ld_data : bus.src_data[i*XLEN +: XLEN];
            end
        end
    end

    // Output register next state: load on accept, empty on drain, hold otherwise
    always_comb begin
        out_valid_d = out_valid_q;
        rf_we_d     = rf_we_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        sel_err_d   = sel_err_q;
        wb_count_d  = wb_count_q + {31'b0, commit};
        if (accept) begin
            out_valid_d = 1'b1;
            rf_we_d     = bus.reg_write & (bus.rd_addr != '0) & sel_ok;
            rf_waddr_d  = bus.rd_addr;
            rf_wdata_d  = sel_data;
            sel_err_d   = sel_err_q | !sel_ok;
        end else if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
            rf_we_d     = 1'b0;
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            sel_err_q   <= 1'b0;
            wb_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            sel_err_q   <= sel_err_d;
            wb_count_q  <= wb_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.rf_we     = rf_we_q & out_valid_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.wb_count  = wb_count_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_select_stage
//  Description : Directed self-checking bench for wb_select_stage: reset,
//                source select, load extension, x0 / illegal select,
//                backpressure streaming, counter wrap and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_select_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_select_stage_if #(.XLEN(32), .NSRC(4), .SEL_W(2), .RA_W(5)) bus_a ();
    wb_select_stage_if #(.XLEN(32), .NSRC(3), .SEL_W(2), .RA_W(5)) bus_b ();

    wb_select_stage #(.XLEN(32), .NSRC(4), .SEL_W(2), .MEM_IDX(1), .RA_W(5)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    wb_select_stage #(.XLEN(32), .NSRC(3), .SEL_W(2), .MEM_IDX(1), .RA_W(5)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    // load vectors on memory word 0x8001_FF80
    logic [2:0]  lf3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b111};
    logic [2:0]  loff [8] = '{3'd0,   3'd0,   3'd2,   3'd2,   3'd0,   3'd1,   3'd3,   3'd1};
    logic [31:0] lexp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                              32'h8001_FF80, 32'hFFFF_FFFF, 32'h0000_0080, 32'h8001_FF80};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic issue_a(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] off,
                           input logic [4:0] rd, input logic we);
        bus_a.wb_sel    = sel;
        bus_a.ld_funct3 = f3;
        bus_a.byte_off  = off;
        bus_a.rd_addr   = rd;
        bus_a.reg_write = we;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid  = 1'b0;
    endtask

    task automatic issue_b(input logic [1:0] sel, input logic [4:0] rd);
        bus_b.wb_sel    = sel;
        bus_b.rd_addr   = rd;
        bus_b.reg_write = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  got;
        int  cyc_done;
        logic acc;

        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1; bus_a.wb_sel = '0; bus_a.reg_write = 1'b0;
        bus_a.rd_addr = '0; bus_a.ld_funct3 = '0; bus_a.byte_off = '0;
        bus_a.src_data = {32'hABCD_E000, 32'h0000_1004, 32'h8001_FF80, 32'h1234_5678};
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.wb_sel = '0; bus_b.reg_write = 1'b0;
        bus_b.rd_addr = '0; bus_b.ld_funct3 = '0; bus_b.byte_off = '0;
        bus_b.src_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        // reset state
        idle();
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_rf_we",     bus_a.rf_we,     0);
        check("rst_rf_waddr",  bus_a.rf_waddr,  0);
        check("rst_rf_wdata",  bus_a.rf_wdata,  0);
        check("rst_sel_err",   bus_a.sel_err,   0);
        check("rst_wb_count",  bus_a.wb_count,  0);
        check("rst_in_ready",  bus_a.in_ready,  1);
        @(negedge clk); rst = 1'b0;
        idle();

        // ALU path
        issue_a(2'd0, 3'b000, 3'd0, 5'd5, 1'b1);
        check("alu_rf_we",    bus_a.rf_we,    1);
        check("alu_rf_waddr", bus_a.rf_waddr, 5);
        check("alu_rf_wdata", bus_a.rf_wdata, 32'h1234_5678);
        check("alu_count_pre", bus_a.wb_count, 0);
        idle();
        exp_count++;
        check("alu_count",    bus_a.wb_count, exp_count);
        check("alu_drained",  bus_a.out_valid, 0);

        // load alignment / extension
        for (int k = 0; k < 8; k++) begin
            issue_a(2'd1, lf3[k], loff[k], 5'(10 + k), 1'b1);
            check($sformatf("load%0d_data", k), bus_a.rf_wdata, lexp[k]);
            idle();
            exp_count++;
        end
        check("load_count", bus_a.wb_count, exp_count);

        // non-memory sources are never extended
        issue_a(2'd2, 3'b000, 3'd1, 5'd20, 1'b1);
        check("pc4_data", bus_a.rf_wdata, 32'h0000_1004);
        idle(); exp_count++;
        issue_a(2'd3, 3'b000, 3'd0, 5'd21, 1'b1);
        check("imm_data", bus_a.rf_wdata, 32'hABCD_E000);
        idle(); exp_count++;

        // x0 write suppression
        issue_a(2'd0, 3'b000, 3'd0, 5'd0, 1'b1);
        check("x0_rf_we",     bus_a.rf_we,     0);
        check("x0_out_valid", bus_a.out_valid, 1);
        idle();
        check("x0_count",     bus_a.wb_count, exp_count);

        // illegal select on the 3-source instance
        issue_b(2'd3, 5'd7);
        check("bad_sel_data",  bus_b.rf_wdata, 0);
        check("bad_sel_we",    bus_b.rf_we,    0);
        check("bad_sel_err",   bus_b.sel_err,  1);
        idle();
        issue_b(2'd0, 5'd7);
        check("bad_sel_next_data", bus_b.rf_wdata, 32'h1111_1111);
        check("bad_sel_sticky",    bus_b.sel_err,  1);
        idle();
        check("bad_sel_count",     bus_b.wb_count, 1);
        check("good_inst_no_err",  bus_a.sel_err,  0);

        // backpressure for 3 cycles, then back-to-back streaming
        idx = 0; got = 0; cyc_done = -1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus_a.in_valid = (idx < 6);
            bus_a.wb_sel = 2'd0; bus_a.reg_write = 1'b1;
            bus_a.rd_addr = 5'(idx + 1);
            bus_a.src_data[31:0] = 32'h100 + 32'(idx);
            bus_a.out_ready = (cyc >= 4);
            #1;
            acc = bus_a.in_valid & bus_a.in_ready;
            if (cyc >= 1 && cyc <= 3) begin
                check("bp_in_ready",  bus_a.in_ready, 0);
                check("bp_hold_data", bus_a.rf_wdata, 32'h100);
            end
            if (bus_a.rf_we & bus_a.out_ready) begin
                check("stream_data", bus_a.rf_wdata, 32'h100 + 32'(got));
                check("stream_addr", bus_a.rf_waddr, 5'(got + 1));
                got++;
                if (got == 6) cyc_done = cyc;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        exp_count += 6;
        check("stream_writes",  got, 6);
        check("stream_cycles",  cyc_done, 9);
        check("stream_drained", bus_a.out_valid, 0);
        check("stream_count",   bus_a.wb_count, exp_count);

        // counter wrap from 0xFFFF_FFFF
        force dut_a.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut_a.wb_count_q;
        issue_a(2'd0, 3'b000, 3'd0, 5'd9, 1'b1);
        check("wrap_pre",  bus_a.wb_count, 32'hFFFF_FFFF);
        idle();
        check("wrap_zero", bus_a.wb_count, 0);

        // asynchronous reset while an instruction is held
        issue_a(2'd0, 3'b000, 3'd0, 5'd4, 1'b1);
        bus_a.out_ready = 1'b0;
        idle();
        check("mid_held_valid", bus_a.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid",  bus_a.out_valid, 0);
        check("mid_rst_we",     bus_a.rf_we,     0);
        check("mid_rst_waddr",  bus_a.rf_waddr,  0);
        check("mid_rst_wdata",  bus_a.rf_wdata,  0);
        check("mid_rst_count",  bus_a.wb_count,  0);
        check("mid_rst_selerr", bus_b.sel_err,   0);
        @(negedge clk); rst = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
